reimu_life_ctrl: RTL



---
 rtl/reimu_life_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/reimu_life_ctrl.sv
// rtl/reimu_life_ctrl.sv - Reimu hit/life manager: lives, invincibility window, sprite blink, game-over
module reimu_life_ctrl #(
  parameter int INIT_LIVES = 3,
  parameter int MAX_LIVES  = 7,
  parameter int INV_TICKS  = 40,
  parameter int BLINK_DIV  = 2
) (
  input  logic       clk22,
  input  logic       rst,
  input  logic       gamestart,
  input  logic       shot,
  input  logic       enemy_shot,
  input  logic       life_up,
  output logic [2:0] lives,
  output logic       invincible,
  output logic       reimu_visible,
  output logic       hit,
  output logic       gameover
);

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    INVINC = 2'd1,
    DEAD   = 2'd2
  } state_t;

  localparam logic [2:0] INIT_L   = 3'(INIT_LIVES);
  localparam logic [3:0] MAX_L    = 4'(MAX_LIVES);
  localparam logic [7:0] INV_LAST = 8'(INV_TICKS - 1);
  localparam logic [3:0] BLK_LAST = 4'(BLINK_DIV - 1);

  state_t     state;
  logic [7:0] inv_cnt;
  logic [3:0] blink_cnt;
  logic       hit_req;
  logic [2:0] lives_inc;
  logic [2:0] lives_after_hit;

  assign hit_req = shot | enemy_shot;

  // lives never exceeds MAX_LIVES, so a hit plus life_up in one cycle nets to no change
  always_comb begin
    lives_inc       = lives;
    lives_after_hit = lives - 3'd1;
    if (life_up && ({1'b0, lives} < MAX_L))
      lives_inc = lives + 3'd1;
    if (life_up)
      lives_after_hit = lives;
  end

  always_ff @(posedge clk22) begin
    if (rst || gamestart) begin
      state         <= PLAY;
      lives         <= INIT_L;
      invincible    <= 1'b0;
      reimu_visible <= 1'b1;
      hit           <= 1'b0;
      gameover      <= 1'b0;
      inv_cnt       <= 8'd0;
      blink_cnt     <= 4'd0;
    end else begin
      case (state)
        PLAY: begin
          if (hit_req) begin
            hit   <= 1'b1;
            lives <= lives_after_hit;
            if (lives_after_hit == 3'd0) begin
              state         <= DEAD;
              gameover      <= 1'b1;
              invincible    <= 1'b0;
              reimu_visible <= 1'b0;
            end else begin
              state         <= INVINC;
              invincible    <= 1'b1;
              inv_cnt       <= INV_LAST;
              reimu_visible <= 1'b0;
              blink_cnt     <= 4'd0;
            end
          end else begin
            hit   <= 1'b0;
            lives <= lives_inc;
          end
        end
        INVINC: begin
          hit   <= 1'b0;
          lives <= lives_inc;
          if (inv_cnt == 8'd0) begin
            state         <= PLAY;
            invincible    <= 1'b0;
            reimu_visible <= 1'b1;
            blink_cnt     <= 4'd0;
          end else begin
            inv_cnt <= inv_cnt - 8'd1;
            if (blink_cnt == BLK_LAST) begin
              blink_cnt     <= 4'd0;
              reimu_visible <= ~reimu_visible;
            end else begin
              blink_cnt <= blink_cnt + 4'd1;
            end
          end
        end
        DEAD: begin
          lives         <= 3'd0;
          gameover      <= 1'b1;
          reimu_visible <= 1'b0;
          invincible    <= 1'b0;
          hit           <= 1'b0;
        end
        default: begin
          state <= PLAY;
          hit   <= 1'b0;
        end
      endcase
    end
  end

endmodule
